// File: rtl/show_ctrl.sv
// show_ctrl: round-robin shares the LCD status fields between two requesters and
// commits the shadowed record to the display outputs only on frame boundaries.
module show_ctrl #(
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned MONEY_MAX   = 99,
  parameter bit          VS_ACT_LOW  = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        lcd_vs,
  input  logic        a_req,
  input  logic [13:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [13:0] b_data,
  output logic        b_ack,
  output logic [3:0]  goods_index,
  output logic [6:0]  money,
  output logic        point_flag,
  output logic [1:0]  money_flag,
  output logic        upd_pending
);

  localparam int unsigned GOODS_W = 4;
  localparam int unsigned MONEY_W = 7;
  localparam int unsigned FLAG_W  = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic               VS_IDLE   = VS_ACT_LOW;
  localparam logic [MONEY_W-1:0] MONEY_CAP = MONEY_W'(MONEY_MAX);
  localparam logic [CNT_W-1:0]   HOLD_CNT  = CNT_W'(HOLD_FRAMES);

  typedef struct packed {
    logic [GOODS_W-1:0] goods;
    logic [MONEY_W-1:0] money;
    logic               point;
    logic [FLAG_W-1:0]  flag;
  } rec_t;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t     state_q, state_d;
  logic       vs_s1_q, vs_s1_d;
  logic       vs_s2_q, vs_s2_d;
  logic       vs_dly_q, vs_dly_d;
  logic       rr_q, rr_d;          // 1: B wins the next contested cycle
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic       pending_q, pending_d;
  rec_t       shadow_q, shadow_d;
  rec_t       disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rec_t       a_rec, b_rec, win_rec;
  logic       frame_tick_c;
  logic       a_elig, b_elig, grant_a, grant_b, grant, commit;

  assign a_rec = rec_t'(a_data);
  assign b_rec = rec_t'(b_data);

  // Active vs edge seen between the last synchroniser stage and its delayed copy.
  assign frame_tick_c = VS_ACT_LOW ? (~vs_s2_q & vs_dly_q) : (vs_s2_q & ~vs_dly_q);

  always_comb begin
    vs_s1_d   = lcd_vs;
    vs_s2_d   = vs_s1_q;
    vs_dly_d  = vs_s2_q;
    rr_d      = rr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    state_d   = state_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    cnt_d     = cnt_q;

    // A requester is not re-granted in the cycle its ack is showing.
    a_elig  = a_req & ~a_ack_q;
    b_elig  = b_req & ~b_ack_q;
    grant_a = a_elig & (~b_elig | ~rr_q);
    grant_b = b_elig & ~grant_a;
    grant   = grant_a | grant_b;

    win_rec = grant_a ? a_rec : b_rec;
    if (win_rec.money > MONEY_CAP) begin
      win_rec.money = MONEY_CAP;
    end

    commit = (state_q == S_PEND) && frame_tick_c;

    case (state_q)
      S_IDLE: if (grant) state_d = S_PEND;
      S_PEND: if (frame_tick_c && !grant) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      shadow_d = win_rec;
      a_ack_d  = grant_a;
      b_ack_d  = grant_b;
      rr_d     = grant_a;
    end

    // Display update and banner hold both happen only on a frame tick.
    if (commit) begin
      disp_d = shadow_q;
      cnt_d  = (shadow_q.flag != '0) ? HOLD_CNT : '0;
    end else if (frame_tick_c && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        disp_d.flag = '0;
      end
    end

    pending_d = (state_d == S_PEND);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      vs_s1_q   <= VS_IDLE;
      vs_s2_q   <= VS_IDLE;
      vs_dly_q  <= VS_IDLE;
      rr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vs_s1_q   <= vs_s1_d;
      vs_s2_q   <= vs_s2_d;
      vs_dly_q  <= vs_dly_d;
      rr_q      <= rr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign goods_index = disp_q.goods;
  assign money       = disp_q.money;
  assign point_flag  = disp_q.point;
  assign money_flag  = disp_q.flag;
  assign upd_pending = pending_q;

endmodule

// File: tb/tb_show_ctrl.sv
// tb_show_ctrl: directed scenarios plus randomized traffic checked against a
// transaction-level model of the display controller.
module tb_show_ctrl;

  localparam int unsigned HOLD = 3;
  localparam int unsigned MMAX = 99;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        lcd_vs;
  logic        a_req, b_req;
  logic [13:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic [3:0]  goods_index;
  logic [6:0]  money;
  logic        point_flag;
  logic [1:0]  money_flag;
  logic        upd_pending;

  show_ctrl #(.HOLD_FRAMES(HOLD), .MONEY_MAX(MMAX), .VS_ACT_LOW(1'b1)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .lcd_vs      (lcd_vs),
    .a_req       (a_req),
    .a_data      (a_data),
    .a_ack       (a_ack),
    .b_req       (b_req),
    .b_data      (b_data),
    .b_ack       (b_ack),
    .goods_index (goods_index),
    .money       (money),
    .point_flag  (point_flag),
    .money_flag  (money_flag),
    .upd_pending (upd_pending)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin history, last written record, displayed record, frames left on banner.
  bit          vs_hist[$];
  bit          m_a_ack, m_b_ack, m_b_next, m_pend;
  logic [13:0] m_shadow, m_disp;
  int          m_left;

  int  vs_timer;
  int  vs_falls = 0;
  bit  rnd = 1'b0;
  int  req_pct = 30;

  function automatic logic [13:0] clamp(input logic [13:0] d);
    logic [13:0] r;
    logic [6:0]  cap;
    r   = d;
    cap = 7'(MMAX);
    if (d[9:3] > cap) r[9:3] = cap;
    return r;
  endfunction

  task automatic model_reset();
    vs_hist  = {1'b1, 1'b1, 1'b1, 1'b1};
    m_a_ack  = 1'b0;
    m_b_ack  = 1'b0;
    m_b_next = 1'b0;
    m_pend   = 1'b0;
    m_shadow = '0;
    m_disp   = '0;
    m_left   = 0;
  endtask

  // Predict one clock of behaviour, advance the clock, then compare.
  task automatic cycle();
    bit tick, ea, eb, ga, gb, commit;
    vs_hist.push_front(lcd_vs);
    if (vs_hist.size() > 4) void'(vs_hist.pop_back());
    tick   = !vs_hist[2] && vs_hist[3];
    ea     = a_req && !m_a_ack;
    eb     = b_req && !m_b_ack;
    ga     = ea && (!eb || !m_b_next);
    gb     = eb && !ga;
    commit = tick && m_pend;
    if (commit) begin
      m_disp = m_shadow;
      m_left = (m_shadow[1:0] != 2'd0) ? int'(HOLD) : 0;
    end else if (tick && m_left > 0) begin
      m_left--;
      if (m_left == 0) m_disp[1:0] = 2'd0;
    end
    if (ga || gb) begin
      m_shadow = clamp(ga ? a_data : b_data);
      m_pend   = 1'b1;
      m_b_next = ga;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    m_a_ack = ga;
    m_b_ack = gb;
    @(posedge sys_clk);
    #1;
    check("ack", 32'({a_ack, b_ack}), 32'({m_a_ack, m_b_ack}));
    check("disp", 32'({goods_index, money, point_flag, money_flag}), 32'(m_disp));
    check("pend", 32'(upd_pending), 32'(m_pend));
  endtask

  task automatic gen_vs();
    if (vs_timer == 0) begin
      lcd_vs = ~lcd_vs;
      if (!lcd_vs) begin
        vs_falls++;
        vs_timer = $urandom_range(1, 3);
      end else begin
        vs_timer = $urandom_range(6, 14);
      end
    end else begin
      vs_timer--;
    end
  endtask

  task automatic step();
    gen_vs();
    cycle();
    if (rnd) begin
      if (a_ack) begin
        if ($urandom_range(0, 1) == 0) a_req = 1'b0;
        else a_data = 14'($urandom);
      end
      if (b_ack) begin
        if ($urandom_range(0, 1) == 0) b_req = 1'b0;
        else b_data = 14'($urandom);
      end
      if (!a_req && $urandom_range(0, 99) < req_pct) begin
        a_req = 1'b1; a_data = 14'($urandom);
      end
      if (!b_req && $urandom_range(0, 99) < req_pct) begin
        b_req = 1'b1; b_data = 14'($urandom);
      end
    end else begin
      if (a_ack) a_req = 1'b0;
      if (b_ack) b_req = 1'b0;
    end
  endtask

  task automatic frames(input int n);
    int target;
    target = vs_falls + n;
    while (vs_falls < target) step();
    repeat (5) step();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge sys_clk);
    #1;
    check("rst_out", 32'({a_ack, b_ack, goods_index, money, point_flag, money_flag, upd_pending}), 32'd0);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    lcd_vs    = 1'b1;
    a_req     = 1'b0;
    b_req     = 1'b0;
    a_data    = '0;
    b_data    = '0;
    vs_timer  = 4;
    repeat (2) @(posedge sys_clk);
    #1;
    check("por_out", 32'({a_ack, b_ack, goods_index, money, point_flag, money_flag, upd_pending}), 32'd0);
    sys_rst_n = 1'b1;
    model_reset();

    // Idle frames leave everything at zero.
    frames(3);
    check("idle_disp", 32'({goods_index, money, money_flag}), 32'd0);

    // Single update appears only after the next frame boundary.
    a_data = {4'd5, 7'd25, 1'b0, 2'd0};
    a_req  = 1'b1;
    step();
    check("t2_ack", 32'(a_ack), 32'd1);
    check("t2_hold", 32'(money), 32'd0);
    frames(1);
    check("t2_goods", 32'(goods_index), 32'd5);
    check("t2_money", 32'(money), 32'd25);

    // Simultaneous requests after reset: A first, B next, B's data wins.
    apply_reset();
    a_data = {4'd1, 7'd10, 1'b0, 2'd0};
    b_data = {4'd2, 7'd20, 1'b1, 2'd0};
    a_req = 1'b1;
    b_req = 1'b1;
    step();
    check("t3_first", 32'({a_ack, b_ack}), 32'b10);
    step();
    check("t3_second", 32'({a_ack, b_ack}), 32'b01);
    frames(1);
    check("t3_last", 32'(goods_index), 32'd2);
    a_req = 1'b1;
    b_req = 1'b1;
    step();
    step();
    frames(1);

    // Money clamp.
    b_data = {4'd7, 7'd120, 1'b0, 2'd0};
    b_req  = 1'b1;
    step();
    frames(1);
    check("t4_clamp", 32'(money), 32'd99);

    // Banner visible for HOLD ticks after commit, cleared on the last.
    a_data = {4'd3, 7'd7, 1'b1, 2'd2};
    a_req  = 1'b1;
    step();
    frames(1);
    check("t5_flag0", 32'(money_flag), 32'd2);
    frames(1);
    check("t5_flag1", 32'(money_flag), 32'd2);
    frames(1);
    check("t5_flag2", 32'(money_flag), 32'd2);
    frames(1);
    check("t5_flag3", 32'(money_flag), 32'd0);
    check("t5_keep", 32'({goods_index, money}), 32'({4'd3, 7'd7}));

    // Reset while pending with a request high; request re-grants after release.
    a_data = {4'd9, 7'd50, 1'b0, 2'd1};
    a_req  = 1'b1;
    step();
    a_req = 1'b1;
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst", 32'({a_ack, b_ack, goods_index, money, point_flag, money_flag, upd_pending}), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    step();
    check("t6_regrant", 32'(a_ack), 32'd1);
    frames(1);

    // Randomized traffic: heavy contention, then sparse updates so banners expire.
    rnd = 1'b1;
    req_pct = 30;
    repeat (1500) step();
    req_pct = 1;
    repeat (1500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
